sweep_divider_ctrl: RTL and testbench
=====================================

// Module: sweep_divider_ctrl
// PURPOSE
//   Sequences a preloadable up-count frequency divider through a programmed sweep of preload values.
//   Holds each value for a programmed number of output periods, then steps to the next one.
//   Emits the divided tick and the square-wave output (psi) consumed by the waveform generator datapath.
//   Supports a single sweep ending in a done pulse, or a continuous looping sweep.
// PARAMETERS
//   W        8   divider/preload width; divider terminal count MAX = 2^W-1
//   DWELL_W  4   width of dwell (ticks per step, minus one)
// PORTS
//   clk        in   1        system clock, all logic on rising edge
//   rst        in   1        synchronous reset, active-high
//   start      in   1        sampled in IDLE only: latch config, begin sweep
//   abort      in   1        terminate sweep, return to IDLE
//   mode       in   1        0 = single sweep, 1 = continuous loop
//   start_val  in   W        first preload value
//   stop_val   in   W        sweep limit (inclusive)
//   step       in   W        preload increment/decrement; 0 treated as 1
//   dwell      in   DWELL_W  ticks per value = dwell+1
//   tick       out  1        one-cycle pulse per divider period
//   psi        out  1        toggles on every tick
//   cur_val    out  W        preload value currently in use
//   busy       out  1        high while sweeping
//   done       out  1        one-cycle pulse at end of single sweep
// BEHAVIOUR
//   - Reset (sync, rst=1 at edge): state=IDLE; cnt=0; dwell_cnt=0.
//     Outputs: tick=0, psi=0, cur_val=0, busy=0, done=0. rst overrides all other inputs.
//   - Config (start_val, stop_val, step, dwell, mode) is latched on the start edge.
//     Input changes during a sweep have no effect.
//   - Direction is UP if start_val <= stop_val, else DOWN. Step arithmetic is done in W+1 bits.
//   - States: IDLE, RUN.
//   - IDLE
//     - start=1 and abort=0: cur_val<=start_val, cnt<=start_val, dwell_cnt<=0, busy<=1, state<=RUN.
//     - abort=1 in the same cycle as start: the start is ignored.
//   - RUN, per edge
//     - cnt!=MAX: cnt<=cnt+1, tick<=0.
//     - cnt==MAX: tick<=1, psi<=~psi, cnt<=reload value.
//       Period = 2^W - cur_val cycles; cur_val==MAX gives a tick every cycle.
//   - On a tick edge with dwell_cnt<dwell: dwell_cnt++, reload value = cur_val.
//   - On a tick edge with dwell_cnt==dwell: dwell_cnt<=0, nxt = cur_val +/- step.
//     - nxt within limit (UP: nxt<=stop_val with no carry; DOWN: nxt>=stop_val with no borrow):
//       cur_val<=nxt, cnt<=nxt.
//     - Past limit, mode=1: cur_val<=start, cnt<=start (wrap).
//     - Past limit, mode=0: state<=IDLE, busy<=0, done<=1 for one cycle.
//       done and busy falling coincide with the final tick cycle.
//       psi holds its last value; cur_val holds the last used value.
//   - Values beyond stop_val are never used; stop_val itself is used only if reached exactly.
//   - abort in RUN: next edge state<=IDLE, busy<=0, tick<=0, psi<=0, done stays 0, cur_val held.
//   - start while busy: ignored.
//   - done is never asserted in mode=1.
// TESTING
//   1. W=8, start=252, stop=254, step=1, dwell=0, mode=0
//      -> ticks 4, 3, 2 cycles apart; cur_val 252 -> 253 -> 254.
//      -> done=1 and busy=0 in the cycle of the 3rd tick; psi ends 1.
//   2. start=stop=250, dwell=2
//      -> 3 ticks spaced 6 cycles, then done; cur_val constant 250.
//   3. Down sweep: start=254, stop=250, step=3
//      -> values 254, 251 only; done after the 251 period; step=0 run behaves as step=1.
//   4. mode=1, start=253, stop=254, then abort after 10 ticks
//      -> value sequence 253, 254, 253, ... with no done.
//      -> after abort: busy=0 next cycle, psi=0, no further ticks.
//   5. rst asserted mid-RUN, and start pulsed while busy
//      -> all outputs 0 on next edge; start during busy leaves the sweep unchanged.
//   6. start=stop=255, dwell=3
//      -> tick high 4 consecutive cycles, psi toggles each cycle, done on the 4th.

Source files
------------

// File: rtl/sweep_divider_ctrl.sv
// -----------------------------------------------------------------------------
// sweep_divider_ctrl
//
// Drives a preloadable up-count frequency divider through a programmed sweep
// of preload values. Each preload value is held for dwell+1 divider periods,
// then the controller steps to the next value (up or down towards stop_val).
// A single sweep finishes with a one-cycle done pulse; continuous mode wraps
// back to the start value and never asserts done.
//
// Ports
//   clk        system clock, everything on the rising edge
//   rst        synchronous active-high reset, overrides all other inputs
//   start      begin a sweep (only honoured while idle and abort is low)
//   abort      end a running sweep and return to idle
//   mode       0 = single sweep, 1 = continuous loop
//   start_val  first preload value
//   stop_val   inclusive sweep limit
//   step       preload increment/decrement (0 behaves as 1)
//   dwell      divider periods per preload value, minus one
//   tick       one-cycle pulse per divider period
//   psi        square wave, toggles on every tick
//   cur_val    preload value currently in use
//   busy       high while a sweep is running
//   done       one-cycle pulse at the end of a single sweep
// -----------------------------------------------------------------------------
module sweep_divider_ctrl #(
  parameter int W       = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [W-1:0]       start_val,
  input  logic [W-1:0]       stop_val,
  input  logic [W-1:0]       step,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick,
  output logic               psi,
  output logic [W-1:0]       cur_val,
  output logic               busy,
  output logic               done
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [W-1:0]       cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  // Configuration captured at the start edge so input changes mid-sweep are inert
  logic [W-1:0]       start_l;
  logic [W-1:0]       stop_l;
  logic [W-1:0]       step_l;
  logic [DWELL_W-1:0] dwell_l;
  logic               mode_l;
  logic               up_l;

  // Candidate next preload value. The extra top bit catches carry (up) or
  // borrow (down) so a step that runs off the end of the range is never used.
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] nxt;
  logic         nxt_ok;

  always_comb begin
    sum  = {1'b0, cur_val} + {1'b0, step_l};
    diff = {1'b0, cur_val} - {1'b0, step_l};
    if (up_l) begin
      nxt    = sum[W-1:0];
      nxt_ok = !sum[W] && (sum[W-1:0] <= stop_l);
    end else begin
      nxt    = diff[W-1:0];
      nxt_ok = !diff[W] && (diff[W-1:0] >= stop_l);
    end
  end

  // Sweep sequencer and divider. The divider counts up from the preload value
  // to MAX; the MAX cycle produces the tick and reloads either the same value
  // (still dwelling) or the next one in the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dwell_cnt <= '0;
      start_l   <= '0;
      stop_l    <= '0;
      step_l    <= ONE;
      dwell_l   <= '0;
      mode_l    <= 1'b0;
      up_l      <= 1'b1;
      tick      <= 1'b0;
      psi       <= 1'b0;
      cur_val   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tick <= 1'b0;
          if (start && !abort) begin
            start_l   <= start_val;
            stop_l    <= stop_val;
            step_l    <= (step == '0) ? ONE : step;
            dwell_l   <= dwell;
            mode_l    <= mode;
            up_l      <= (start_val <= stop_val);
            cur_val   <= start_val;
            cnt       <= start_val;
            dwell_cnt <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            tick  <= 1'b0;
            psi   <= 1'b0;
          end else if (cnt != MAX) begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
          end else begin
            tick <= 1'b1;
            psi  <= ~psi;
            if (dwell_cnt != dwell_l) begin
              dwell_cnt <= dwell_cnt + 1'b1;
              cnt       <= cur_val;
            end else begin
              dwell_cnt <= '0;
              if (nxt_ok) begin
                cur_val <= nxt;
                cnt     <= nxt;
              end else if (mode_l) begin
                cur_val <= start_l;
                cnt     <= start_l;
              end else begin
                // Final tick of a single sweep: cur_val and psi keep their values
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_divider_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sweep_divider_ctrl
//
// Scoreboard bench for sweep_divider_ctrl. Each sweep request is expanded by a
// reference model into the list of ticks it must produce (absolute cycle,
// cur_val after the tick, psi, busy, done). A monitor pops one entry per
// observed tick and compares. Directed sweeps are followed by random sweeps.
// -----------------------------------------------------------------------------
module tb_sweep_divider_ctrl;

  localparam int W       = 8;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic               mode;
  logic [W-1:0]       start_val;
  logic [W-1:0]       stop_val;
  logic [W-1:0]       step;
  logic [DWELL_W-1:0] dwell;
  logic               tick;
  logic               psi;
  logic [W-1:0]       cur_val;
  logic               busy;
  logic               done;

  typedef struct {
    int         t;
    logic [7:0] cur;
    logic       psi;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  logic m_psi  = 1'b0;

  sweep_divider_ctrl #(.W(W), .DWELL_W(DWELL_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .start_val(start_val),
    .stop_val (stop_val),
    .step     (step),
    .dwell    (dwell),
    .tick     (tick),
    .psi      (psi),
    .cur_val  (cur_val),
    .busy     (busy),
    .done     (done)
  );

  // 10 ns clock and a free-running cycle counter used to timestamp ticks
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: walks the sweep value by value with plain integer
  // arithmetic. Each value lasts 256-v cycles and is used dwell+1 times.
  task automatic model_sweep(input int s, input int e, input int st, input int dw,
                             input int md, input int maxt, input int base);
    int   v;
    int   t;
    int   n;
    int   nv;
    int   stp;
    bit   up;
    bit   ok;
    exp_t r;
    up  = (s <= e);
    stp = (st == 0) ? 1 : st;
    v   = s;
    t   = base;
    n   = 0;
    forever begin
      for (int d = 0; d <= dw; d++) begin
        t     += 256 - v;
        m_psi  = ~m_psi;
        r.t    = t;
        r.psi  = m_psi;
        r.busy = 1'b1;
        r.done = 1'b0;
        if (d == dw) begin
          nv = up ? v + stp : v - stp;
          ok = up ? (nv <= e) : (nv >= e);
          if (ok) v = nv;
          else if (md != 0) v = s;
          else begin
            r.busy = 1'b0;
            r.done = 1'b1;
          end
        end
        r.cur = 8'(v);
        exp_q.push_back(r);
        n++;
        if (r.done || (md != 0 && n >= maxt)) return;
      end
    end
  endtask

  // Monitor: every tick must match the next scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (!tick && done) checkOutput("done_without_tick", int'(done), 0);
    if (tick) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_tick", int'(tick), 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("tick_cycle", cyc, e.t);
        checkOutput("tick_cur_val", int'(cur_val), int'(e.cur));
        checkOutput("tick_psi", int'(psi), int'(e.psi));
        checkOutput("tick_busy", int'(busy), int'(e.busy));
        checkOutput("tick_done", int'(done), int'(e.done));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_psi = 1'b0;
  endtask

  // Issue a sweep request, record its expected ticks, then scramble the
  // config inputs to show that only the start-edge values matter.
  task automatic applyStimulus(input int s, input int e, input int st, input int dw,
                               input int md, input int maxt);
    @(negedge clk);
    start_val = 8'(s);
    stop_val  = 8'(e);
    step      = 8'(st);
    dwell     = 4'(dw);
    mode      = md[0];
    abort     = 1'b0;
    start     = 1'b1;
    model_sweep(s, e, st, dw, md, maxt, cyc + 1);
    @(negedge clk);
    start     = 1'b0;
    start_val = 8'($urandom);
    stop_val  = 8'($urandom);
    step      = 8'($urandom);
    dwell     = 4'($urandom);
    mode      = 1'($urandom);
    checkOutput("busy_after_start", int'(busy), 1);
    checkOutput("cur_val_after_start", int'(cur_val), s);
  endtask

  task automatic wait_idle();
    int budget;
    budget = ((exp_q.size() > 0) ? (exp_q[$].t - cyc) : 0) + 50;
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("sweep_ends_idle", int'(busy), 0);
    checkOutput("ticks_outstanding", exp_q.size(), 0);
    if (busy || exp_q.size() != 0) do_reset();
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d passed", passes, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   budget;
    logic [7:0] last_cur;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    start_val = '0; stop_val = '0; step = '0; dwell = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tick", int'(tick), 0);
    checkOutput("reset_psi", int'(psi), 0);
    checkOutput("reset_cur_val", int'(cur_val), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    rst = 1'b0;

    // Basic up sweep, single-value dwell sweep, down sweep, step of zero
    applyStimulus(252, 254, 1, 0, 0, 0); wait_idle();
    checkOutput("up_sweep_psi_end", int'(psi), 1);
    applyStimulus(250, 250, 1, 2, 0, 0); wait_idle();
    applyStimulus(254, 250, 3, 0, 0, 0); wait_idle();
    checkOutput("down_sweep_cur_held", int'(cur_val), 251);
    applyStimulus(252, 254, 0, 0, 0, 0); wait_idle();

    // Start together with abort is ignored
    @(negedge clk);
    start_val = 8'd200; stop_val = 8'd210; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start_with_abort_busy", int'(busy), 0);

    // Continuous loop, abort after 10 ticks
    applyStimulus(253, 254, 1, 0, 1, 10);
    last_cur = exp_q[$].cur;
    budget = exp_q[$].t - cyc + 50;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("loop_ticks_outstanding", exp_q.size(), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    m_psi = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_psi", int'(psi), 0);
    checkOutput("abort_tick", int'(tick), 0);
    checkOutput("abort_cur_val", int'(cur_val), int'(last_cur));
    repeat (20) @(negedge clk);

    // Start while busy is ignored, then reset in mid-sweep
    applyStimulus(240, 250, 1, 1, 0, 0);
    repeat (30) @(negedge clk);
    start_val = 8'd100; stop_val = 8'd120; step = 8'd5; dwell = 4'd0; mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("busy_before_reset", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrun_reset_tick", int'(tick), 0);
    checkOutput("midrun_reset_psi", int'(psi), 0);
    checkOutput("midrun_reset_cur_val", int'(cur_val), 0);
    checkOutput("midrun_reset_busy", int'(busy), 0);
    checkOutput("midrun_reset_done", int'(done), 0);
    rst = 1'b0;
    exp_q.delete();
    m_psi = 1'b0;

    // Preload of MAX ticks every cycle
    applyStimulus(255, 255, 1, 3, 0, 0); wait_idle();

    // Random single sweeps in the upper range to keep periods short
    for (int k = 0; k < 8; k++) begin
      applyStimulus($urandom_range(224, 255), $urandom_range(224, 255),
                    $urandom_range(0, 7), $urandom_range(0, 3), 0, 0);
      wait_idle();
    end

    // Random continuous sweep ended by abort
    applyStimulus($urandom_range(240, 250), $urandom_range(240, 250), $urandom_range(1, 4), 0, 1, 6);
    last_cur = exp_q[$].cur;
    budget = exp_q[$].t - cyc + 50;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("rand_loop_ticks_outstanding", exp_q.size(), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    m_psi = 1'b0;
    checkOutput("rand_abort_busy", int'(busy), 0);
    checkOutput("rand_abort_cur_val", int'(cur_val), int'(last_cur));
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
